// File: rtl/counter_run_ctrl_pkg.sv
// Shared definitions for the demo-counter run controller: FSM state encodings
// used by the controller, the LED decode and the bench.
package counter_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_IDLE      = 2'd1,
        ST_RUN       = 2'd2,
        ST_PAUSE     = 2'd3
    } state_e;

endpackage

// File: rtl/counter_run_ctrl_if.sv
// Link between the run controller and the 3-bit demo counter: enable/clear/direction
// towards the counter, current count value back from it.
interface counter_run_ctrl_if #(
    parameter int CNT_W = 3
);
    logic             cnt_en;
    logic             cnt_up;
    logic             cnt_clr;
    logic [CNT_W-1:0] count;

    modport master (output cnt_en, output cnt_up, output cnt_clr, input count);
    modport slave  (input cnt_en, input cnt_up, input cnt_clr, output count);
endinterface

// File: rtl/counter_run_ctrl_tick_gen.sv
// Count-step timebase: free-running 0..TICK_DIV-1 counter while running, frozen on hold,
// cleared otherwise. tick_o flags the terminal value.
module tick_gen #(
    parameter int TICK_DIV = 8000000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic run_i,
    input  logic hold_i,
    input  logic restart_i,
    output logic tick_o
);
    localparam int            TW   = $clog2(TICK_DIV);
    localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (restart_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end else if (hold_i) begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);
endmodule

// File: rtl/counter_run_ctrl.sv
// Run/pause/step/clear sequencer for the demo counter, producing a single-cycle count
// enable on the PLL clock and holding the counter cleared until the PLL is locked.
module counter_run_ctrl
    import counter_run_ctrl_pkg::*;
#(
    parameter int TICK_DIV    = 8000000,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      pll_locked_i,
    input  logic                      start_i,
    input  logic                      stop_i,
    input  logic                      step_i,
    input  logic                      clear_i,
    input  logic                      dir_up_i,
    input  logic                      one_shot_i,
    counter_run_ctrl_if.master        ctr,
    output logic [1:0]                state_o,
    output logic                      busy_o
);
    localparam int            LW        = $clog2(LOCK_CYCLES + 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);

    state_e        state_q, state_d;
    logic [LW-1:0] lock_q, lock_d;
    logic          start_prev_q, stop_prev_q, step_prev_q, clear_prev_q;
    logic          cnt_en_q, cnt_en_d;
    logic          cnt_clr_q, cnt_clr_d;
    logic          cnt_up_q;
    logic          busy_q;

    logic start_rise, stop_rise, step_rise, clear_rise;
    logic tick, run, hold, restart, at_terminal;

    assign start_rise = start_i & ~start_prev_q;
    assign stop_rise  = stop_i  & ~stop_prev_q;
    assign step_rise  = step_i  & ~step_prev_q;
    assign clear_rise = clear_i & ~clear_prev_q;

    // Terminal count depends on the direction the counter is actually being driven in.
    assign at_terminal = cnt_up_q ? (&ctr.count) : ~(|ctr.count);

    always_comb begin
        state_d   = state_q;
        lock_d    = '0;
        cnt_en_d  = 1'b0;
        cnt_clr_d = 1'b0;
        if (!pll_locked_i) begin
            state_d = ST_WAIT_LOCK;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    if (lock_q == LOCK_LAST) state_d = ST_IDLE;
                    else                     lock_d  = lock_q + 1'b1;
                end
                ST_IDLE, ST_PAUSE: begin
                    if (start_rise)      state_d   = ST_RUN;
                    else if (clear_rise) cnt_clr_d = 1'b1;
                    else if (step_rise)  cnt_en_d  = 1'b1;
                end
                ST_RUN: begin
                    if (stop_rise) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        if (one_shot_i && at_terminal) state_d  = ST_IDLE;
                        else                           cnt_en_d = 1'b1;
                    end
                end
                default: state_d = ST_WAIT_LOCK;
            endcase
        end
        if (state_d == ST_WAIT_LOCK) cnt_clr_d = 1'b1;
        cnt_en_d = cnt_en_d & ~cnt_clr_d;
    end

    // The tick count survives a pause and the resume out of it; any other exit clears it.
    assign run     = (state_q == ST_RUN) && (state_d == ST_RUN);
    assign hold    = (state_d == ST_PAUSE) || ((state_q == ST_PAUSE) && (state_d == ST_RUN));
    assign restart = (state_q == ST_IDLE) && (state_d == ST_RUN);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .run_i     (run),
        .hold_i    (hold),
        .restart_i (restart),
        .tick_o    (tick)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_WAIT_LOCK;
            lock_q       <= '0;
            cnt_en_q     <= 1'b0;
            cnt_clr_q    <= 1'b1;
            cnt_up_q     <= 1'b1;
            busy_q       <= 1'b0;
            start_prev_q <= 1'b1;
            stop_prev_q  <= 1'b1;
            step_prev_q  <= 1'b1;
            clear_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            lock_q       <= lock_d;
            cnt_en_q     <= cnt_en_d;
            cnt_clr_q    <= cnt_clr_d;
            cnt_up_q     <= dir_up_i;
            busy_q       <= (state_d == ST_RUN);
            start_prev_q <= start_i;
            stop_prev_q  <= stop_i;
            step_prev_q  <= step_i;
            clear_prev_q <= clear_i;
        end
    end

    assign ctr.cnt_en  = cnt_en_q;
    assign ctr.cnt_clr = cnt_clr_q;
    assign ctr.cnt_up  = cnt_up_q;
    assign state_o     = state_q;
    assign busy_o      = busy_q;
endmodule

// File: tb/tb_counter_run_ctrl.sv
// Scoreboard bench for counter_run_ctrl with TICK_DIV=4, LOCK_CYCLES=3, CNT_W=3.
module tb_counter_run_ctrl;
    import counter_run_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset_i, pll_locked_i, start_i, stop_i, step_i, clear_i, dir_up_i, one_shot_i;
    logic [1:0] state_w;
    logic       busy_w;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic       en;
        logic       clr;
        logic       up;
    } exp_t;
    exp_t sb[$];

    counter_run_ctrl_if #(.CNT_W(3)) cif ();

    counter_run_ctrl #(
        .TICK_DIV    (4),
        .LOCK_CYCLES (3)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .pll_locked_i (pll_locked_i),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .step_i       (step_i),
        .clear_i      (clear_i),
        .dir_up_i     (dir_up_i),
        .one_shot_i   (one_shot_i),
        .ctr          (cif),
        .state_o      (state_w),
        .busy_o       (busy_w)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int c, input logic [1:0] act, input logic [1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", name, c, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs against the expectation queued for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                check("state",   e.cyc, state_w,             e.st);
                check("cnt_en",  e.cyc, {1'b0, cif.cnt_en},  {1'b0, e.en});
                check("cnt_clr", e.cyc, {1'b0, cif.cnt_clr}, {1'b0, e.clr});
                check("cnt_up",  e.cyc, {1'b0, cif.cnt_up},  {1'b0, e.up});
                check("busy",    e.cyc, {1'b0, busy_w},      {1'b0, (e.st == ST_RUN)});
            end
        end
    end

    // Queue the outputs expected after the coming clock edge, then advance one cycle.
    task automatic step_clk(input logic [1:0] st, input logic en, input logic clr);
        exp_t e;
        e.cyc = cyc + 1;
        e.st  = st;
        e.en  = en;
        e.clr = clr;
        e.up  = reset_i ? 1'b1 : dir_up_i;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_n(input int n, input logic [1:0] st);
        for (int i = 0; i < n; i++) step_clk(st, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_i = 1'b1; pll_locked_i = 1'b0; start_i = 1'b0; stop_i = 1'b0;
        step_i = 1'b0; clear_i = 1'b0; dir_up_i = 1'b1; one_shot_i = 1'b0;
        cif.count = 3'd0;
        step_clk(ST_WAIT_LOCK, 0, 1);
        step_clk(ST_WAIT_LOCK, 0, 1);

        // Lock-up
        reset_i = 1'b0; pll_locked_i = 1'b1;
        step_clk(ST_WAIT_LOCK, 0, 1);
        step_clk(ST_WAIT_LOCK, 0, 1);
        step_clk(ST_IDLE, 0, 0);
        step_clk(ST_IDLE, 0, 0);
        dir_up_i = 1'b0;
        step_clk(ST_IDLE, 0, 0);
        dir_up_i = 1'b1;
        step_clk(ST_IDLE, 0, 0);

        // Run cadence: pulse every 4 cycles, first one 4 cycles after entry
        start_i = 1'b1;
        step_clk(ST_RUN, 0, 0);
        for (int i = 1; i <= 12; i++) step_clk(ST_RUN, (i % 4 == 0), 0);
        start_i = 1'b0;

        // Pause two cycles into a period, resume finishes the remaining two
        run_n(2, ST_RUN);
        stop_i = 1'b1;
        step_clk(ST_PAUSE, 0, 0);
        stop_i = 1'b0;
        run_n(5, ST_PAUSE);
        start_i = 1'b1;
        step_clk(ST_RUN, 0, 0);
        start_i = 1'b0;
        step_clk(ST_RUN, 0, 0);
        step_clk(ST_RUN, 1, 0);
        stop_i = 1'b1;
        step_clk(ST_PAUSE, 0, 0);
        stop_i = 1'b0; step_i = 1'b1;
        step_clk(ST_PAUSE, 1, 0);
        step_i = 1'b0;
        run_n(2, ST_PAUSE);
        clear_i = 1'b1;
        step_clk(ST_PAUSE, 0, 1);
        clear_i = 1'b0;
        step_clk(ST_PAUSE, 0, 0);

        // One-shot counting up: pulses at 5 and 6, stop at 7
        one_shot_i = 1'b1; cif.count = 3'd5; start_i = 1'b1;
        step_clk(ST_RUN, 0, 0);
        start_i = 1'b0;
        run_n(3, ST_RUN);
        step_clk(ST_RUN, 1, 0);
        cif.count = 3'd6;
        run_n(3, ST_RUN);
        step_clk(ST_RUN, 1, 0);
        cif.count = 3'd7;
        run_n(3, ST_RUN);
        step_clk(ST_IDLE, 0, 0);
        step_clk(ST_IDLE, 0, 0);
        one_shot_i = 1'b0;

        // Lock loss mid-RUN
        start_i = 1'b1;
        step_clk(ST_RUN, 0, 0);
        start_i = 1'b0;
        step_clk(ST_RUN, 0, 0);
        pll_locked_i = 1'b0;
        step_clk(ST_WAIT_LOCK, 0, 1);
        pll_locked_i = 1'b1;
        step_clk(ST_WAIT_LOCK, 0, 1);
        step_clk(ST_WAIT_LOCK, 0, 1);
        step_clk(ST_IDLE, 0, 0);

        // Priority: stop beats start in RUN
        start_i = 1'b1;
        step_clk(ST_RUN, 0, 0);
        start_i = 1'b0;
        run_n(2, ST_RUN);
        stop_i = 1'b1; start_i = 1'b1;
        step_clk(ST_PAUSE, 0, 0);
        stop_i = 1'b0; start_i = 1'b0;
        step_clk(ST_PAUSE, 0, 0);
        pll_locked_i = 1'b0;
        step_clk(ST_WAIT_LOCK, 0, 1);
        pll_locked_i = 1'b1;
        run_n(0, ST_IDLE);
        step_clk(ST_WAIT_LOCK, 0, 1);
        step_clk(ST_WAIT_LOCK, 0, 1);
        step_clk(ST_IDLE, 0, 0);

        // Priority: clear beats step in IDLE; step alone pulses once
        clear_i = 1'b1; step_i = 1'b1;
        step_clk(ST_IDLE, 0, 1);
        clear_i = 1'b0; step_i = 1'b0;
        step_clk(ST_IDLE, 0, 0);
        step_i = 1'b1;
        step_clk(ST_IDLE, 1, 0);
        step_clk(ST_IDLE, 0, 0);
        step_i = 1'b0;

        // Start held through reset never produces a RUN entry
        start_i = 1'b1; reset_i = 1'b1;
        step_clk(ST_WAIT_LOCK, 0, 1);
        step_clk(ST_WAIT_LOCK, 0, 1);
        reset_i = 1'b0;
        step_clk(ST_WAIT_LOCK, 0, 1);
        step_clk(ST_WAIT_LOCK, 0, 1);
        run_n(3, ST_IDLE);
        start_i = 1'b0;

        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d pending want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
